// File: rtl/pong_responder.sv
// Responder side of the ping/pong handshake: each accepted ping returns one
// registered pong DELAY edges later, with a small pending buffer and a pong limit.
module pong_responder #(
    parameter int DELAY  = 1,
    parameter int QDEPTH = 2,
    parameter int LIMIT  = 10,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ping,
    output logic             pong,
    output logic             busy,
    output logic [3:0]       pending,
    output logic [CNT_W-1:0] ping_count,
    output logic [CNT_W-1:0] pong_count,
    output logic             overrun,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PONG,
        S_DONE
    } state_t;

    localparam logic [7:0]       TIMER_LOAD = 8'(DELAY - 1);
    localparam logic [3:0]       QDEPTH_L   = 4'(QDEPTH);
    localparam logic [CNT_W-1:0] LIMIT_L    = CNT_W'(LIMIT);
    localparam bit               HAS_LIMIT  = (LIMIT != 0);

    state_t           r_state;
    logic [7:0]       r_timer;
    logic [3:0]       r_pending;
    logic [CNT_W-1:0] r_ping_count;
    logic [CNT_W-1:0] r_pong_count;
    logic             r_pong;
    logic             r_overrun;
    logic             r_done;

    state_t           w_state_nxt;
    logic [7:0]       w_timer_nxt;
    logic [3:0]       w_pending_nxt;
    logic [CNT_W-1:0] w_pong_count_nxt;
    logic [CNT_W-1:0] w_pong_count_inc;
    logic             w_pong_nxt;
    logic             w_overrun_nxt;
    logic             w_done_nxt;
    logic             w_buffer_ping;

    assign w_pong_count_inc = r_pong_count + CNT_W'(1);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer;
        w_pending_nxt    = r_pending;
        w_pong_count_nxt = r_pong_count;
        w_pong_nxt       = 1'b0;
        w_overrun_nxt    = r_overrun;
        w_done_nxt       = r_done;
        w_buffer_ping    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (ping) begin
                    w_state_nxt = S_WAIT;
                    w_timer_nxt = TIMER_LOAD;
                end
            end
            S_WAIT: begin
                w_buffer_ping = ping;
                if (r_timer != 8'd0) begin
                    w_timer_nxt = r_timer - 8'd1;
                end else begin
                    w_state_nxt      = S_PONG;
                    w_pong_nxt       = 1'b1;
                    w_pong_count_nxt = w_pong_count_inc;
                    if (HAS_LIMIT && (w_pong_count_inc == LIMIT_L)) begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_PONG: begin
                if (r_done) begin
                    w_state_nxt   = S_DONE;
                    w_buffer_ping = ping;
                end else if (r_pending != 4'd0) begin
                    // Start from the buffer; a coincident ping refills the freed slot.
                    w_state_nxt   = S_WAIT;
                    w_timer_nxt   = TIMER_LOAD;
                    w_pending_nxt = r_pending - 4'd1;
                    w_buffer_ping = ping;
                end else if (ping) begin
                    w_state_nxt = S_WAIT;
                    w_timer_nxt = TIMER_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_DONE;
            end
        endcase

        if (w_buffer_ping) begin
            if (w_pending_nxt < QDEPTH_L) begin
                w_pending_nxt = w_pending_nxt + 4'd1;
            end else begin
                w_overrun_nxt = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_timer      <= 8'd0;
            r_pending    <= 4'd0;
            r_ping_count <= '0;
            r_pong_count <= '0;
            r_pong       <= 1'b0;
            r_overrun    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_pending    <= w_pending_nxt;
            r_pong_count <= w_pong_count_nxt;
            r_pong       <= w_pong_nxt;
            r_overrun    <= w_overrun_nxt;
            r_done       <= w_done_nxt;
            if (ping) begin
                r_ping_count <= r_ping_count + CNT_W'(1);
            end
        end
    end

    assign pong       = r_pong;
    assign busy       = (r_state == S_WAIT) || (r_state == S_PONG);
    assign pending    = r_pending;
    assign ping_count = r_ping_count;
    assign pong_count = r_pong_count;
    assign overrun    = r_overrun;
    assign done       = r_done;

endmodule

// File: tb/tb_pong_responder.sv
// Scoreboard bench for pong_responder: expected pong edges are queued as pings
// are driven and matched against observed pongs on three DELAY variants.
module tb_pong_responder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ping1 = 1'b0;
    logic       ping3 = 1'b0;
    logic       ping5 = 1'b0;

    logic       pong1, busy1, ovr1, done1;
    logic [3:0] pend1;
    logic [7:0] pingc1, pongc1;
    logic       pong3, busy3, ovr3, done3;
    logic [3:0] pend3;
    logic [7:0] pingc3, pongc3;
    logic       pong5, busy5, ovr5, done5;
    logic [3:0] pend5;
    logic [7:0] pingc5, pongc5;

    int n_checks = 0;
    int n_fails  = 0;
    int edge_n   = 0;
    int base     = 0;
    int exp_q1[$];
    int exp_q3[$];
    int exp_q5[$];

    pong_responder #(.DELAY(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .ping(ping1), .pong(pong1), .busy(busy1),
        .pending(pend1), .ping_count(pingc1), .pong_count(pongc1),
        .overrun(ovr1), .done(done1)
    );

    pong_responder #(.DELAY(3), .QDEPTH(2)) u_d3 (
        .clk(clk), .rst_n(rst_n), .ping(ping3), .pong(pong3), .busy(busy3),
        .pending(pend3), .ping_count(pingc3), .pong_count(pongc3),
        .overrun(ovr3), .done(done3)
    );

    pong_responder #(.DELAY(5)) u_d5 (
        .clk(clk), .rst_n(rst_n), .ping(ping5), .pong(pong5), .busy(busy5),
        .pending(pend5), .ping_count(pingc5), .pong_count(pongc5),
        .overrun(ovr5), .done(done5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Pong monitors: every observed pong must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && pong1) begin
            n_checks++;
            if (exp_q1.size() == 0) begin
                n_fails++;
                $display("FAIL pong_d1: pong at edge %0d, none expected", edge_n - base);
            end else begin
                int e;
                e = exp_q1.pop_front();
                if (edge_n - base !== e) begin
                    n_fails++;
                    $display("FAIL pong_d1: pong at edge %0d, expected edge %0d", edge_n - base, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && pong3) begin
            n_checks++;
            if (exp_q3.size() == 0) begin
                n_fails++;
                $display("FAIL pong_d3: pong at edge %0d, none expected", edge_n - base);
            end else begin
                int e;
                e = exp_q3.pop_front();
                if (edge_n - base !== e) begin
                    n_fails++;
                    $display("FAIL pong_d3: pong at edge %0d, expected edge %0d", edge_n - base, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && pong5) begin
            n_checks++;
            if (exp_q5.size() == 0) begin
                n_fails++;
                $display("FAIL pong_d5: pong at edge %0d, none expected", edge_n - base);
            end else begin
                int e;
                e = exp_q5.pop_front();
                if (edge_n - base !== e) begin
                    n_fails++;
                    $display("FAIL pong_d5: pong at edge %0d, expected edge %0d", edge_n - base, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int r);
        while (edge_n - base < r) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ping1 = 1'b0;
        ping3 = 1'b0;
        ping5 = 1'b0;
        step();
        step();
        exp_q1.delete();
        exp_q3.delete();
        exp_q5.delete();
        rst_n = 1'b1;
        base  = edge_n;
    endtask

    // Drive a ping sampled at relative edge r; exp_rel >= 0 queues the expected pong edge.
    task automatic ping_at(input int which, input int r, input int exp_rel);
        go_to(r - 1);
        case (which)
            1: begin if (exp_rel >= 0) exp_q1.push_back(exp_rel); ping1 = 1'b1; end
            3: begin if (exp_rel >= 0) exp_q3.push_back(exp_rel); ping3 = 1'b1; end
            default: begin if (exp_rel >= 0) exp_q5.push_back(exp_rel); ping5 = 1'b1; end
        endcase
        step();
        ping1 = 1'b0;
        ping3 = 1'b0;
        ping5 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({pong1, busy1, pend1, pingc1, pongc1, ovr1, done1} !== '0) begin
            n_fails++;
            $display("FAIL reset_state_d1: got %h, expected 0",
                     {pong1, busy1, pend1, pingc1, pongc1, ovr1, done1});
        end
        do_reset();
        go_to(20);
        n_checks++;
        if ({pong1, busy1, pend1, pingc1, pongc1, ovr1, done1} !== '0) begin
            n_fails++;
            $display("FAIL idle_d1: got %h, expected 0", {pong1, busy1, pend1, pingc1, pongc1, ovr1, done1});
        end
        n_checks++;
        if ({pong3, busy3, pend3, pingc3, pongc3, ovr3, done3} !== '0) begin
            n_fails++;
            $display("FAIL idle_d3: got %h, expected 0", {pong3, busy3, pend3, pingc3, pongc3, ovr3, done3});
        end
        n_checks++;
        if ({pong5, busy5, pend5, pingc5, pongc5, ovr5, done5} !== '0) begin
            n_fails++;
            $display("FAIL idle_d5: got %h, expected 0", {pong5, busy5, pend5, pingc5, pongc5, ovr5, done5});
        end
    endtask

    task automatic test_single_ping();
        do_reset();
        ping_at(1, 5, 6);
        for (int r = 5; r <= 8; r++) begin
            go_to(r);
            n_checks++;
            if (busy1 !== (r < 7)) begin
                n_fails++;
                $display("FAIL single_busy: edge %0d busy=%b, expected %b", r, busy1, (r < 7));
            end
        end
        n_checks++;
        if (pongc1 !== 8'd1 || pingc1 !== 8'd1) begin
            n_fails++;
            $display("FAIL single_counts: ping_count=%0d pong_count=%0d, expected 1 and 1", pingc1, pongc1);
        end
        n_checks++;
        if (exp_q1.size() != 0) begin
            n_fails++;
            $display("FAIL single_missing: %0d pongs not seen, expected 0", exp_q1.size());
        end
    endtask

    task automatic test_buffering();
        do_reset();
        ping_at(3, 5, 8);
        ping_at(3, 6, 12);
        n_checks++;
        if (pend3 !== 4'd1) begin
            n_fails++;
            $display("FAIL buf_pending_e6: got %0d, expected 1", pend3);
        end
        ping_at(3, 7, 16);
        n_checks++;
        if (pend3 !== 4'd2) begin
            n_fails++;
            $display("FAIL buf_pending_e7: got %0d, expected 2", pend3);
        end
        go_to(9);
        n_checks++;
        if (pend3 !== 4'd1) begin
            n_fails++;
            $display("FAIL buf_pending_e9: got %0d, expected 1", pend3);
        end
        go_to(20);
        n_checks++;
        if (pend3 !== 4'd0 || ovr3 !== 1'b0 || pongc3 !== 8'd3) begin
            n_fails++;
            $display("FAIL buf_final: pending=%0d overrun=%b pong_count=%0d, expected 0 0 3", pend3, ovr3, pongc3);
        end
        n_checks++;
        if (exp_q3.size() != 0) begin
            n_fails++;
            $display("FAIL buf_missing: %0d pongs not seen, expected 0", exp_q3.size());
        end
    endtask

    task automatic test_overrun();
        do_reset();
        ping_at(3, 5, 8);
        ping_at(3, 6, 12);
        ping_at(3, 7, 16);
        n_checks++;
        if (ovr3 !== 1'b0) begin
            n_fails++;
            $display("FAIL ovr_early: overrun=%b, expected 0", ovr3);
        end
        ping_at(3, 8, -1);
        n_checks++;
        if (ovr3 !== 1'b1) begin
            n_fails++;
            $display("FAIL ovr_set: overrun=%b, expected 1", ovr3);
        end
        go_to(25);
        n_checks++;
        if (ovr3 !== 1'b1 || pongc3 !== 8'd3 || pingc3 !== 8'd4 || pend3 !== 4'd0) begin
            n_fails++;
            $display("FAIL ovr_final: overrun=%b pong_count=%0d ping_count=%0d pending=%0d, expected 1 3 4 0",
                     ovr3, pongc3, pingc3, pend3);
        end
        n_checks++;
        if (exp_q3.size() != 0) begin
            n_fails++;
            $display("FAIL ovr_missing: %0d pongs not seen, expected 0", exp_q3.size());
        end
    endtask

    task automatic test_ping_pong_loop();
        int r;
        int k;
        do_reset();
        r = 5;
        for (int i = 0; i < 10; i++) begin
            ping_at(1, r, r + 1);
            k = 0;
            while (!pong1 && k < 4) begin
                step();
                k++;
            end
            n_checks++;
            if (!pong1) begin
                n_fails++;
                $display("FAIL loop_timeout: round %0d no pong within 4 edges", i);
            end else if (done1 !== (i == 9)) begin
                n_fails++;
                $display("FAIL loop_done: round %0d done=%b, expected %b", i, done1, (i == 9));
            end
            r = (edge_n - base) + 2;
        end
        ping_at(1, r, -1);
        go_to(r + 10);
        n_checks++;
        if (pingc1 !== 8'd11 || pongc1 !== 8'd10 || done1 !== 1'b1 || busy1 !== 1'b0) begin
            n_fails++;
            $display("FAIL loop_final: ping_count=%0d pong_count=%0d done=%b busy=%b, expected 11 10 1 0",
                     pingc1, pongc1, done1, busy1);
        end
        n_checks++;
        if (exp_q1.size() != 0) begin
            n_fails++;
            $display("FAIL loop_missing: %0d pongs not seen, expected 0", exp_q1.size());
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        ping_at(5, 5, -1);
        go_to(7);
        n_checks++;
        if (busy5 !== 1'b1) begin
            n_fails++;
            $display("FAIL rstw_busy_before: busy=%b, expected 1", busy5);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy5 !== 1'b0 || pingc5 !== 8'd0) begin
            n_fails++;
            $display("FAIL rstw_async: busy=%b ping_count=%0d, expected 0 0", busy5, pingc5);
        end
        go_to(8);
        rst_n = 1'b1;
        go_to(11);
        n_checks++;
        if (pingc5 !== 8'd0 || pongc5 !== 8'd0 || busy5 !== 1'b0) begin
            n_fails++;
            $display("FAIL rstw_cleared: ping_count=%0d pong_count=%0d busy=%b, expected 0 0 0",
                     pingc5, pongc5, busy5);
        end
        ping_at(5, 12, 17);
        go_to(20);
        n_checks++;
        if (pongc5 !== 8'd1 || pingc5 !== 8'd1) begin
            n_fails++;
            $display("FAIL rstw_counts: ping_count=%0d pong_count=%0d, expected 1 1", pingc5, pongc5);
        end
        n_checks++;
        if (exp_q5.size() != 0) begin
            n_fails++;
            $display("FAIL rstw_missing: %0d pongs not seen, expected 0", exp_q5.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_ping();
        test_buffering();
        test_overrun();
        test_ping_pong_loop();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
